key_loader: RTL and testbench
=============================

KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 The parameter KEY_W SHALL be declared as: KEY_W, default 39, total key width (4 mux-select bits + 35 XOR bits).
REQ-002 The port clk SHALL be: clk  input  1  single clock; all state changes on rising edge.
REQ-003 The port rst SHALL be: rst  input  1  asynchronous, active-high reset.
REQ-004 The port key_start SHALL be: key_start  input  1  one-cycle pulse that begins a load frame.
REQ-005 The port key_in SHALL be: key_in  input  1  serial key/parity data bit.
REQ-006 The port key_valid SHALL be: key_valid  input  1  key_in carries a bit this cycle.
REQ-007 The port key_clear SHALL be: key_clear  input  1  zeroes the active key.
REQ-008 The port key_rdy SHALL be: key_rdy  output  1  loader accepts a bit this cycle.
REQ-009 The port key_p SHALL be: key_p  output  4  active mux-select key; key_p[i] drives lock input p(i+1).
REQ-010 The port key_x SHALL be: key_x  output  35  active XOR key; key_x[i] drives lock input X_(i+1).
REQ-011 The port key_ok SHALL be: key_ok  output  1  the active key came from a frame that passed the parity check.
REQ-012 The port busy SHALL be: busy  output  1  a frame is in progress.
REQ-013 The port err SHALL be: err  output  1  sticky flag for the last completed frame; set on a parity failure.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and CHECK.
REQ-015 In IDLE, a key_start pulse SHALL move the FSM to SHIFT, clear the bit counter to 0 and clear err.
REQ-016 In SHIFT, key_rdy SHALL be 1; in all other states it SHALL be 0.
REQ-017 In SHIFT, a bit SHALL be transferred only on a cycle where key_valid=1 and key_rdy=1.
REQ-018 A cycle in SHIFT with key_valid=0 SHALL be a stall, with no state change and no upper bound on stall length.
REQ-019 A frame SHALL be exactly 40 transferred bits: key bits K[38] down to K[0], MSB first, then one parity bit.
REQ-020 Key bits SHALL shift into a 39-bit shadow register: shadow <= {shadow[37:0], key_in}.
REQ-021 The 6-bit counter SHALL increment by 1 on each transfer.
REQ-022 The parity accumulator SHALL XOR in every transferred bit, including the parity bit.
REQ-023 When transfer number 40 (counter=39) completes, the FSM SHALL go to CHECK on the next edge.
REQ-024 CHECK SHALL last exactly one cycle and then return to IDLE.
REQ-025 In CHECK, if the accumulated XOR of all 40 bits is 1 (odd parity), the design SHALL load key_p <= shadow[38:35] and key_x <= shadow[34:0] and set key_ok=1.
REQ-026 In CHECK, if the accumulated XOR is 0, the design SHALL set err=1 and leave key_p, key_x and key_ok unchanged.
REQ-027 The active key SHALL become visible in the cycle after CHECK, giving a latency of 1 cycle from the edge that ends CHECK.
REQ-028 busy SHALL be 1 in SHIFT and CHECK, and 0 in IDLE.
REQ-029 A key_start pulse during SHIFT SHALL abort the frame, zero the counter, shadow and parity accumulator, and stay in SHIFT; that cycle's bit SHALL be discarded.
REQ-030 key_start during CHECK SHALL be ignored.
REQ-031 key_clear SHALL set key_p=0, key_x=0 and key_ok=0 on the next edge, in any state, without affecting the FSM.
REQ-032 If key_clear and a CHECK commit occur in the same cycle, clear SHALL win; err still updates per REQ-026.
REQ-033 The active key registers SHALL never change except on a commit, a clear or a reset, so no partial key is ever driven to the locked netlist.
REQ-034 The counter SHALL never exceed 39, and no wrap-around SHALL occur.

Reset
REQ-035 On rst=1, asynchronously: state=IDLE; counter, shadow and parity=0; key_p=4'h0, key_x=35'h0, key_ok=0, busy=0, err=0, key_rdy=0.
REQ-036 Reset asserted mid-frame SHALL discard the frame entirely.
REQ-037 After deassertion, the loader SHALL accept no bit until a new key_start.

Verification
REQ-038 Scenario 1: start, then 39 zeros + parity 1, with key_valid held -> 41 cycles later key_ok=1, key_p=0, key_x=0, err=0.
REQ-039 Scenario 2: start, then 39 ones + parity 0 -> key_p=4'hF, key_x=35'h7_FFFF_FFFF, key_ok=1.
REQ-040 Scenario 3: start, then 39 ones + parity 1 -> err=1, key_ok and key outputs keep their previous values.
REQ-041 Scenario 4: key_p=4'b1010 / key_x=35'h5_5555_5555 frame with random key_valid gaps of 0-5 cycles -> same committed value as the gap-free run; key_rdy stays 1 throughout the gaps.
REQ-042 Scenario 5: key_start again after 20 bits, then a full valid all-ones frame -> the commit reflects only the second frame.
REQ-043 Scenario 6: rst pulsed at bit 30 -> all outputs 0 immediately; key_clear coincident with CHECK -> key_ok=0, key outputs 0.

Source files
------------

// File: rtl/key_loader.sv
// Serial key loader: shifts a 39-bit key plus one parity bit into a shadow
// register and commits it to the active key outputs only on odd parity.
module key_loader #(
  parameter int KEY_W = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_in,
  input  logic             key_valid,
  input  logic             key_clear,
  output logic             key_rdy,
  output logic [3:0]       key_p,
  output logic [KEY_W-5:0] key_x,
  output logic             key_ok,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

  // Counter value during the final (parity) transfer of a frame.
  localparam logic [5:0] LAST_CNT = 6'(KEY_W);

  state_e             r_state;
  state_e             w_next;
  logic [5:0]         r_cnt;
  logic [KEY_W-1:0]   r_shadow;
  logic               r_parity;
  logic [3:0]         r_key_p;
  logic [KEY_W-5:0]   r_key_x;
  logic               r_key_ok;
  logic               r_err;

  logic w_start_frame;
  logic w_xfer;
  logic w_last;
  logic w_commit;

  // A start in SHIFT aborts the frame and wins over that cycle's bit.
  assign w_start_frame = key_start && (r_state != CHECK);
  assign w_xfer        = (r_state == SHIFT) && key_valid && !key_start;
  assign w_last        = (r_cnt == LAST_CNT);
  assign w_commit      = (r_state == CHECK) && r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      // NOTE: every clocked register uses non-blocking assignment so all flops update from pre-edge values.
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned and infers a latch.
    w_next  = r_state;
    key_rdy = 1'b0;
    busy    = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_start) w_next = SHIFT;
      end
      SHIFT: begin
        key_rdy = 1'b1;
        busy    = 1'b1;
        if (w_xfer && w_last) w_next = CHECK;
      end
      CHECK: begin
        busy   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow register is a plain flop bank, so it is reset like any other state.
      r_cnt    <= '0;
      r_shadow <= '0;
      r_parity <= 1'b0;
      r_key_p  <= '0;
      r_key_x  <= '0;
      r_key_ok <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_start_frame) begin
        r_cnt    <= '0;
        r_shadow <= '0;
        r_parity <= 1'b0;
      end else if (w_xfer) begin
        r_parity <= r_parity ^ key_in;
        // The parity bit is not shifted and the counter holds at its last value.
        if (!w_last) begin
          r_shadow <= {r_shadow[KEY_W-2:0], key_in};
          r_cnt    <= r_cnt + 6'd1;
        end
      end

      if ((r_state == IDLE) && key_start) begin
        r_err <= 1'b0;
      end else if ((r_state == CHECK) && !r_parity) begin
        r_err <= 1'b1;
      end

      // Clear has priority over a commit landing on the same edge.
      if (key_clear) begin
        r_key_p  <= '0;
        r_key_x  <= '0;
        r_key_ok <= 1'b0;
      end else if (w_commit) begin
        r_key_p  <= r_shadow[KEY_W-1:KEY_W-4];
        r_key_x  <= r_shadow[KEY_W-5:0];
        r_key_ok <= 1'b1;
      end
    end
  end

  assign key_p  = r_key_p;
  assign key_x  = r_key_x;
  assign key_ok = r_key_ok;
  assign err    = r_err;

endmodule

// File: tb/tb_key_loader.sv
// Randomized bench for key_loader: a frame-level model built from a bit queue
// predicts every output each cycle, plus directed end-of-frame value checks.
module tb_key_loader;

  localparam int KEY_W = 39;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_start;
  logic        key_in;
  logic        key_valid;
  logic        key_clear;
  logic        key_rdy;
  logic [3:0]  key_p;
  logic [34:0] key_x;
  logic        key_ok;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_loader #(.KEY_W(KEY_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_clear (key_clear),
    .key_rdy   (key_rdy),
    .key_p     (key_p),
    .key_x     (key_x),
    .key_ok    (key_ok),
    .busy      (busy),
    .err       (err)
  );

  // Reference model: a frame is "open", "being judged" or absent; received
  // bits are kept in a queue and judged by their overall XOR.
  typedef enum {M_IDLE, M_RECV, M_JUDGE} m_phase_e;

  m_phase_e    m_phase;
  bit          m_bits[$];
  logic [38:0] m_key;
  logic        m_ok;
  logic        m_err;

  function automatic void model_reset();
    m_phase = M_IDLE;
    m_bits.delete();
    m_key   = '0;
    m_ok    = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_edge();
    bit commit = 1'b0;
    bit parity = 1'b0;
    case (m_phase)
      M_IDLE: if (key_start) begin
        m_phase = M_RECV;
        m_bits.delete();
        m_err = 1'b0;
      end
      M_RECV: begin
        if (key_start) begin
          m_bits.delete();
        end else if (key_valid) begin
          m_bits.push_back(key_in);
          if (m_bits.size() == 40) m_phase = M_JUDGE;
        end
      end
      M_JUDGE: begin
        foreach (m_bits[i]) parity ^= m_bits[i];
        if (parity) commit = 1'b1;
        else        m_err  = 1'b1;
        m_phase = M_IDLE;
      end
      default: m_phase = M_IDLE;
    endcase
    if (key_clear) begin
      m_key = '0;
      m_ok  = 1'b0;
    end else if (commit) begin
      for (int i = 0; i < 39; i++) m_key[38-i] = m_bits[i];
      m_ok = 1'b1;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("key_p",   64'(key_p),   64'(m_key[38:35]));
    check("key_x",   64'(key_x),   64'(m_key[34:0]));
    check("key_ok",  64'(key_ok),  64'(m_ok));
    check("err",     64'(err),     64'(m_err));
    check("busy",    64'(busy),    64'(m_phase != M_IDLE));
    check("key_rdy", 64'(key_rdy), 64'(m_phase == M_RECV));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_all();
  endtask

  task automatic start_pulse();
    key_start = 1'b1;
    step();
    key_start = 1'b0;
  endtask

  task automatic send_bit(input bit b, input int max_gap);
    int gap = $urandom_range(max_gap, 0);
    key_valid = 1'b0;
    repeat (gap) begin
      key_in = 1'($urandom);
      step();
    end
    key_valid = 1'b1;
    key_in    = b;
    step();
    key_valid = 1'b0;
  endtask

  // Leaves the loader in CHECK; end_frame supplies the CHECK-cycle inputs.
  task automatic send_frame(input logic [38:0] k, input bit p, input int max_gap);
    start_pulse();
    for (int i = 38; i >= 0; i--) send_bit(k[i], max_gap);
    send_bit(p, max_gap);
  endtask

  task automatic end_frame(input bit clr, input bit st);
    key_clear = clr;
    key_start = st;
    step();
    key_clear = 1'b0;
    key_start = 1'b0;
  endtask

  initial begin
    logic [38:0] k;
    rst = 1'b1; key_start = 1'b0; key_in = 1'b0; key_valid = 1'b0; key_clear = 1'b0;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    step();

    // Scenario 1: all-zero key with parity 1.
    send_frame(39'h0, 1'b1, 0);
    end_frame(1'b0, 1'b0);
    check("s1_ok",  64'(key_ok), 64'h1);
    check("s1_p",   64'(key_p),  64'h0);
    check("s1_x",   64'(key_x),  64'h0);
    check("s1_err", 64'(err),    64'h0);

    // Scenario 2: all-ones key with parity 0.
    send_frame({39{1'b1}}, 1'b0, 0);
    end_frame(1'b0, 1'b0);
    check("s2_ok", 64'(key_ok), 64'h1);
    check("s2_p",  64'(key_p),  64'hF);
    check("s2_x",  64'(key_x),  64'h7_FFFF_FFFF);

    // Scenario 3: bad parity leaves the previous key; start during CHECK ignored.
    send_frame({39{1'b1}}, 1'b1, 0);
    end_frame(1'b0, 1'b1);
    check("s3_err",  64'(err),    64'h1);
    check("s3_ok",   64'(key_ok), 64'h1);
    check("s3_p",    64'(key_p),  64'hF);
    check("s3_x",    64'(key_x),  64'h7_FFFF_FFFF);
    check("s3_busy", 64'(busy),   64'h0);

    // Scenario 4: patterned key with random valid gaps.
    k = {4'b1010, 35'h5_5555_5555};
    send_frame(k, ~(^k), 5);
    end_frame(1'b0, 1'b0);
    check("s4_p",   64'(key_p),  64'hA);
    check("s4_x",   64'(key_x),  64'h5_5555_5555);
    check("s4_ok",  64'(key_ok), 64'h1);
    check("s4_err", 64'(err),    64'h0);

    // Scenario 5: abort after 20 bits, then a clean all-ones frame.
    start_pulse();
    for (int i = 0; i < 20; i++) send_bit(1'($urandom), 1);
    send_frame({39{1'b1}}, 1'b0, 0);
    end_frame(1'b0, 1'b0);
    check("s5_p", 64'(key_p), 64'hF);
    check("s5_x", 64'(key_x), 64'h7_FFFF_FFFF);

    // Scenario 6a: asynchronous reset at bit 30.
    start_pulse();
    for (int i = 0; i < 30; i++) send_bit(1'b1, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check("s6_rst_ok",   64'(key_ok),  64'h0);
    check("s6_rst_p",    64'(key_p),   64'h0);
    check("s6_rst_x",    64'(key_x),   64'h0);
    check("s6_rst_busy", 64'(busy),    64'h0);
    check("s6_rst_rdy",  64'(key_rdy), 64'h0);
    step();
    rst = 1'b0;
    key_valid = 1'b1;
    key_in    = 1'b1;
    repeat (3) step();
    key_valid = 1'b0;

    // Scenario 6b: commit a key, then clear coincident with a good CHECK.
    k = 39'h12_3456_789A;
    send_frame(k, ~(^k), 0);
    end_frame(1'b0, 1'b0);
    check("s6_pre_ok", 64'(key_ok), 64'h1);
    send_frame({39{1'b1}}, 1'b0, 1);
    end_frame(1'b1, 1'b0);
    check("s6_clr_ok", 64'(key_ok), 64'h0);
    check("s6_clr_p",  64'(key_p),  64'h0);
    check("s6_clr_x",  64'(key_x),  64'h0);

    // Random frames: random key/parity/gaps, occasional aborts and clears.
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        start_pulse();
        for (int i = 0; i < int'($urandom_range(38, 1)); i++) send_bit(1'($urandom), 2);
      end
      k = {7'($urandom), 32'($urandom)};
      send_frame(k, 1'($urandom), 3);
      end_frame(($urandom_range(4, 0) == 0), 1'($urandom));
      key_clear = ($urandom_range(5, 0) == 0);
      key_valid = 1'($urandom);
      key_in    = 1'($urandom);
      repeat (2) step();
      key_clear = 1'b0;
      key_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
